// File: rtl/whack_scorer.sv
// Whack-a-mole judge: syncs and debounces the four active-low keys, scores hits
// and misses against the latched mole target, and flags game over.
module whack_scorer #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int MAX_MISSES      = 5,
   parameter int SCORE_W         = 8
) (
   input  logic               CLOCK_50,
   input  logic               reset,
   input  logic [3:0]         mole,
   input  logic               mole_new,
   input  logic [3:0]         KEY,
   output logic [3:0]         mole_show,
   output logic [SCORE_W-1:0] score,
   output logic [3:0]         misses,
   output logic               hit_pulse,
   output logic               miss_pulse,
   output logic               game_over
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, ARMED, WAIT, OVER} state_t;

   state_t             state, state_n;
   logic [3:0]         sync1, sync2, level, db, db_prev, press;
   logic [3:0]         target, target_n;
   logic [SCORE_W-1:0] score_n;
   logic [3:0]         misses_n;
   logic               hit_n, miss_n, do_miss;
   logic               valid, hit, wrong;

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         sync1   <= 4'hF;
         sync2   <= 4'hF;
         db_prev <= 4'h0;
      end else begin
         sync1   <= KEY;
         sync2   <= sync1;
         db_prev <= db;
      end
   end

   assign level = ~sync2;

   // A flip needs DEBOUNCE_CYCLES consecutive samples that disagree with db.
   for (genvar i = 0; i < 4; i++) begin : g_deb
      logic [CNT_W-1:0] cnt;
      logic             db_bit;
      always_ff @(posedge CLOCK_50) begin
         if (reset) begin
            cnt    <= '0;
            db_bit <= 1'b0;
         end else if (level[i] != db_bit) begin
            if (cnt == CNT_LAST) begin
               db_bit <= level[i];
               cnt    <= '0;
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
         end else begin
            cnt <= '0;
         end
      end
      assign db[i] = db_bit;
   end

   assign press = db & ~db_prev;
   assign valid = mole_new && (mole != 4'd0) && ((mole & (mole - 4'd1)) == 4'd0);
   assign wrong = |(press & ~target);
   assign hit   = |(press & target) && !wrong;

   always_comb begin
      state_n  = state;
      target_n = target;
      score_n  = score;
      misses_n = misses;
      hit_n    = 1'b0;
      miss_n   = 1'b0;
      do_miss  = 1'b0;
      case (state)
         IDLE, WAIT: begin
            if (valid) begin
               target_n = mole;
               state_n  = ARMED;
            end
         end
         ARMED: begin
            if (wrong) begin
               do_miss = 1'b1;
               state_n = WAIT;
            end else if (hit) begin
               score_n = (score == '1) ? score : score + SCORE_W'(1);
               hit_n   = 1'b1;
               state_n = WAIT;
            end else if (valid) begin
               do_miss = 1'b1;
            end
            // A press in the same cycle was judged against the old target above.
            if (valid) begin
               target_n = mole;
               state_n  = ARMED;
            end
         end
         default: ;
      endcase
      if (do_miss) begin
         misses_n = misses + 4'd1;
         miss_n   = 1'b1;
         if (misses_n == 4'(MAX_MISSES)) state_n = OVER;
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state      <= IDLE;
         target     <= 4'h0;
         score      <= '0;
         misses     <= 4'h0;
         hit_pulse  <= 1'b0;
         miss_pulse <= 1'b0;
         game_over  <= 1'b0;
         mole_show  <= 4'h0;
      end else begin
         state      <= state_n;
         target     <= target_n;
         score      <= score_n;
         misses     <= misses_n;
         hit_pulse  <= hit_n;
         miss_pulse <= miss_n;
         game_over  <= (state_n == OVER);
         mole_show  <= (state_n == ARMED) ? target_n : 4'h0;
      end
   end

endmodule

// File: tb/tb_whack_scorer.sv
// Directed bench for whack_scorer: a rule-level game model is compared on every
// cycle, plus literal checks at the hand-computed points of each scenario.
module tb_whack_scorer;

   localparam int D  = 4;
   localparam int MM = 3;
   localparam int SW = 8;
   localparam int P_IDLE = 0, P_ARMED = 1, P_WAIT = 2, P_OVER = 3;

   logic          CLOCK_50, reset, mole_new;
   logic [3:0]    mole, KEY, mole_show, misses;
   logic [SW-1:0] score;
   logic          hit_pulse, miss_pulse, game_over;

   whack_scorer #(.DEBOUNCE_CYCLES(D), .MAX_MISSES(MM), .SCORE_W(SW)) dut (
      .CLOCK_50(CLOCK_50), .reset(reset), .mole(mole), .mole_new(mole_new), .KEY(KEY),
      .mole_show(mole_show), .score(score), .misses(misses), .hit_pulse(hit_pulse),
      .miss_pulse(miss_pulse), .game_over(game_over)
   );

   initial begin
      CLOCK_50 = 1'b0;
      forever #5 CLOCK_50 = ~CLOCK_50;
   end

   int n_checks = 0, n_pass = 0, hit_seen = 0;
   bit started = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      else n_pass++;
   endtask

   // Game model: debounce as "last D synced samples all disagree", then game rules.
   int          m_phase = P_IDLE, m_score = 0, m_misses = 0;
   logic [3:0]  m_target = 0, m_show = 0, m_s1 = 0, m_s2 = 0, m_db = 0, m_pend = 0;
   bit          m_hit = 0, m_miss = 0, m_over = 0;
   int unsigned m_hist [4] = '{0, 0, 0, 0};

   task automatic model_step();
      bit valid, miss_now;
      int unsigned mask, w;
      if (reset) begin
         m_phase = P_IDLE; m_score = 0; m_misses = 0; m_target = 0; m_show = 0;
         m_s1 = 0; m_s2 = 0; m_db = 0; m_pend = 0; m_hit = 0; m_miss = 0; m_over = 0;
         for (int i = 0; i < 4; i++) m_hist[i] = 0;
         return;
      end
      valid = mole_new && ($countones(mole) == 1);
      m_hit = 0; m_miss = 0; miss_now = 0;
      case (m_phase)
         P_IDLE, P_WAIT: if (valid) begin m_target = mole; m_phase = P_ARMED; end
         P_ARMED: begin
            if (m_pend != 0) begin
               if ((m_pend & ~m_target) != 0) miss_now = 1;
               else begin
                  m_hit = 1;
                  if (m_score < (1 << SW) - 1) m_score++;
               end
               m_phase = P_WAIT;
            end else if (valid) miss_now = 1;
            if (valid) begin m_target = mole; m_phase = P_ARMED; end
         end
         default: ;
      endcase
      if (miss_now) begin
         m_misses++; m_miss = 1;
         if (m_misses == MM) m_phase = P_OVER;
      end
      m_over = (m_phase == P_OVER);
      m_show = (m_phase == P_ARMED) ? m_target : 4'h0;
      mask = (1 << D) - 1;
      m_pend = 0;
      for (int i = 0; i < 4; i++) begin
         m_hist[i] = {m_hist[i][30:0], m_s2[i]};
         w = m_hist[i] & mask;
         if ((m_db[i] == 1'b0) ? (w == mask) : (w == 0)) begin
            m_db[i] = ~m_db[i];
            m_pend[i] = m_db[i];
         end
      end
      m_s2 = m_s1;
      m_s1 = ~KEY;
   endtask

   always @(posedge CLOCK_50) model_step();

   always @(negedge CLOCK_50) begin
      if (started) begin
         check("mole_show", mole_show, m_show);
         check("score", score, m_score);
         check("misses", misses, m_misses);
         check("hit_pulse", hit_pulse, m_hit);
         check("miss_pulse", miss_pulse, m_miss);
         check("game_over", game_over, m_over);
         if (hit_pulse === 1'b1) hit_seen++;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge CLOCK_50);
      #1;
   endtask

   task automatic pulse_mole(input logic [3:0] m);
      mole = m; mole_new = 1'b1;
      tick(1);
      mole_new = 1'b0;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_show"}, mole_show, 0);
      check({tag, "_score"}, score, 0);
      check({tag, "_misses"}, misses, 0);
      check({tag, "_pulses"}, {hit_pulse, miss_pulse}, 0);
      check({tag, "_over"}, game_over, 0);
   endtask

   int h0;

   initial begin
      reset = 1'b1; mole = 4'h0; mole_new = 1'b0; KEY = 4'hF;
      @(posedge CLOCK_50); started = 1; tick(1);
      reset = 1'b0;
      check_zero("reset");

      // invalid strobes from IDLE
      pulse_mole(4'b0110); check("idle_multi_show", mole_show, 0);
      pulse_mole(4'b0000); check("idle_zero_show", mole_show, 0);

      // 1: hit exactly 7 cycles after the key edge
      pulse_mole(4'b0100); check("t1_show", mole_show, 4'b0100);
      KEY = 4'b1011;
      tick(6); check("t1_early", hit_pulse, 0);
      tick(1); check("t1_hit", hit_pulse, 1);
      check("t1_score", score, 1); check("t1_show0", mole_show, 0);
      tick(3); KEY = 4'hF; tick(8);

      // 2: chatter yields a single press
      pulse_mole(4'b0100); h0 = hit_seen;
      for (int i = 0; i < 6; i++) begin KEY[2] = ~KEY[2]; tick(2); end
      KEY[2] = 1'b0; tick(10);
      check("t2_hits", hit_seen - h0, 1); check("t2_score", score, 2);
      KEY = 4'hF; tick(8);

      // 3: wrong key alongside the right one is a miss
      pulse_mole(4'b0001); KEY = 4'b0110;
      tick(7); check("t3_miss", miss_pulse, 1);
      check("t3_misses", misses, 1); check("t3_score", score, 2);
      KEY = 4'hF; tick(8);

      // 5: invalid strobes from WAIT; press judged against old target
      pulse_mole(4'b0110); check("t5_multi_show", mole_show, 0);
      pulse_mole(4'b0000); check("t5_zero_show", mole_show, 0);
      pulse_mole(4'b0010); check("t5_armed_show", mole_show, 4'b0010);
      KEY = 4'b1101; tick(6);
      mole = 4'b1000; mole_new = 1'b1; tick(1); mole_new = 1'b0;
      check("t5_hit", hit_pulse, 1); check("t5_score", score, 3);
      check("t5_newtarget", mole_show, 4'b1000);
      KEY = 4'hF; tick(8);

      // reset mid-debounce, then 4: timeouts end the game
      KEY = 4'b1110; tick(3); reset = 1'b1; tick(1);
      check_zero("rst_mid");
      reset = 1'b0; KEY = 4'hF; tick(8);
      pulse_mole(4'b0001);
      pulse_mole(4'b0010); check("t4_miss1", miss_pulse, 1);
      pulse_mole(4'b0100); check("t4_miss2", miss_pulse, 1);
      pulse_mole(4'b1000); check("t4_miss3", miss_pulse, 1);
      check("t4_misses", misses, 3); check("t4_over", game_over, 1);
      check("t4_show", mole_show, 0);
      KEY = 4'b1110; tick(10); pulse_mole(4'b0001); KEY = 4'hF; tick(8);
      check("t4_frozen_m", misses, 3); check("t4_frozen_s", score, 0);
      check("t4_still_over", game_over, 1);

      // 6: reset from OVER, then saturate the score
      reset = 1'b1; tick(1);
      check_zero("rst_over");
      reset = 1'b0; tick(2);
      for (int k = 0; k < 255; k++) begin
         pulse_mole(4'b0001); KEY = 4'b1110; tick(8); KEY = 4'hF; tick(7);
      end
      check("t6_score255", score, 255);
      h0 = hit_seen;
      pulse_mole(4'b0001); KEY = 4'b1110; tick(8); KEY = 4'hF; tick(7);
      check("t6_sat_hit", hit_seen - h0, 1); check("t6_sat_score", score, 255);
      reset = 1'b1; tick(1);
      check_zero("rst_final");
      reset = 1'b0; tick(2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
